id_stage: RTL and testbench

//  RV32I decode stage. Sits directly downstream of the fetch stage and consumes its

---
 rtl/id_stage.sv | 200 ++++++++++++++++++++
 tb/tb_id_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// RV32I decode stage: register file with write-through bypass, instruction decode,
// and the ID/EX pipeline register with flush/stall control.
module id_stage #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic            i_if_valid,
  input  logic [XLEN-1:0] i_if_pc,
  input  logic [31:0]     i_if_instr,
  input  logic            i_wb_en,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_id_valid,
  output logic [XLEN-1:0] o_id_pc,
  output logic [4:0]      o_id_rs1,
  output logic [4:0]      o_id_rs2,
  output logic [4:0]      o_id_rd,
  output logic [XLEN-1:0] o_id_rs1_data,
  output logic [XLEN-1:0] o_id_rs2_data,
  output logic [XLEN-1:0] o_id_imm,
  output logic [3:0]      o_id_alu_op,
  output logic [2:0]      o_id_funct3,
  output logic [6:0]      o_id_ctrl,
  output logic            o_id_illegal
);

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASS = 4'd10;

  // ctrl bit order: {src_a_pc, src_b_imm, reg_we, mem_rd, mem_wr, branch, jump}
  localparam logic [6:0] C_JUMP = 7'h01, C_BRANCH = 7'h02, C_MEM_WR = 7'h04,
                         C_MEM_RD = 7'h08, C_REG_WE = 7'h10, C_SRC_B_IMM = 7'h20,
                         C_SRC_A_PC = 7'h40;

  logic [XLEN-1:0] r_regs [0:NUM_REGS-1];

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [3:0]      w_alu_op;
  logic [6:0]      w_ctrl;
  logic            w_illegal;
  logic [XLEN-1:0] w_imm;
  logic            w_use_rs1, w_use_rs2, w_use_rd;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0] w_rs1_data, w_rs2_data;

  assign w_opcode = i_if_instr[6:0];
  assign w_funct3 = i_if_instr[14:12];
  assign w_funct7 = i_if_instr[31:25];

  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_from_f3 = ALU_SLL;
      3'd2:    alu_from_f3 = ALU_SLT;
      3'd3:    alu_from_f3 = ALU_SLTU;
      3'd4:    alu_from_f3 = ALU_XOR;
      3'd5:    alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_from_f3 = ALU_OR;
      default: alu_from_f3 = ALU_AND;
    endcase
  endfunction

  always_comb begin
    w_alu_op  = ALU_ADD;
    w_ctrl    = '0;
    w_illegal = 1'b0;
    w_imm     = '0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_rd  = 1'b0;
    case (w_opcode)
      7'b0110011: begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1;
        w_alu_op  = alu_from_f3(w_funct3, w_funct7[5]);
        w_ctrl    = C_REG_WE;
        w_illegal = !((w_funct7 == 7'b0000000) ||
                      (w_funct7 == 7'b0100000 && (w_funct3 == 3'd0 || w_funct3 == 3'd5)));
      end
      7'b0010011: begin
        w_use_rs1 = 1'b1; w_use_rd = 1'b1;
        w_imm     = {{20{i_if_instr[31]}}, i_if_instr[31:20]};
        // funct7[5] only distinguishes SRAI; ADDI never becomes SUB
        w_alu_op  = alu_from_f3(w_funct3, (w_funct3 == 3'd5) && w_funct7[5]);
        w_ctrl    = C_SRC_B_IMM | C_REG_WE;
        if (w_funct3 == 3'd1)
          w_illegal = (w_funct7 != 7'b0000000);
        else if (w_funct3 == 3'd5)
          w_illegal = (w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000);
      end
      7'b0000011: begin
        w_use_rs1 = 1'b1; w_use_rd = 1'b1;
        w_imm     = {{20{i_if_instr[31]}}, i_if_instr[31:20]};
        w_ctrl    = C_SRC_B_IMM | C_MEM_RD | C_REG_WE;
        w_illegal = (w_funct3 == 3'd3) || (w_funct3 == 3'd6) || (w_funct3 == 3'd7);
      end
      7'b0100011: begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_imm     = {{20{i_if_instr[31]}}, i_if_instr[31:25], i_if_instr[11:7]};
        w_ctrl    = C_SRC_B_IMM | C_MEM_WR;
        w_illegal = (w_funct3 > 3'd2);
      end
      7'b1100011: begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_imm     = {{19{i_if_instr[31]}}, i_if_instr[31], i_if_instr[7],
                     i_if_instr[30:25], i_if_instr[11:8], 1'b0};
        w_alu_op  = ALU_SUB;
        w_ctrl    = C_BRANCH;
        w_illegal = (w_funct3 == 3'd2) || (w_funct3 == 3'd3);
      end
      7'b1101111: begin
        w_use_rd = 1'b1;
        w_imm    = {{11{i_if_instr[31]}}, i_if_instr[31], i_if_instr[19:12],
                    i_if_instr[20], i_if_instr[30:21], 1'b0};
        w_ctrl   = C_SRC_A_PC | C_JUMP | C_REG_WE;
      end
      7'b1100111: begin
        w_use_rs1 = 1'b1; w_use_rd = 1'b1;
        w_imm     = {{20{i_if_instr[31]}}, i_if_instr[31:20]};
        w_ctrl    = C_SRC_B_IMM | C_JUMP | C_REG_WE;
        w_illegal = (w_funct3 != 3'd0);
      end
      7'b0110111: begin
        w_use_rd = 1'b1;
        w_imm    = {i_if_instr[31:12], 12'b0};
        w_alu_op = ALU_PASS;
        w_ctrl   = C_REG_WE;
      end
      7'b0010111: begin
        w_use_rd = 1'b1;
        w_imm    = {i_if_instr[31:12], 12'b0};
        w_ctrl   = C_SRC_A_PC | C_SRC_B_IMM | C_REG_WE;
      end
      default: w_illegal = 1'b1;
    endcase
    // An illegal word must not write registers or memory downstream
    if (w_illegal) begin
      w_alu_op  = ALU_ADD;
      w_ctrl    = '0;
      w_imm     = '0;
      w_use_rs1 = 1'b0;
      w_use_rs2 = 1'b0;
      w_use_rd  = 1'b0;
    end
  end

  assign w_rs1 = w_use_rs1 ? i_if_instr[19:15] : 5'd0;
  assign w_rs2 = w_use_rs2 ? i_if_instr[24:20] : 5'd0;
  assign w_rd  = w_use_rd  ? i_if_instr[11:7]  : 5'd0;

  assign w_rs1_data = (w_rs1 == 5'd0) ? '0 :
                      (i_wb_en && i_wb_rd == w_rs1) ? i_wb_data : r_regs[w_rs1];
  assign w_rs2_data = (w_rs2 == 5'd0) ? '0 :
                      (i_wb_en && i_wb_rd == w_rs2) ? i_wb_data : r_regs[w_rs2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_wb_en && i_wb_rd != 5'd0) begin
      r_regs[i_wb_rd] <= i_wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || i_flush) begin
      o_id_valid    <= 1'b0;
      o_id_pc       <= '0;
      o_id_rs1      <= '0;
      o_id_rs2      <= '0;
      o_id_rd       <= '0;
      o_id_rs1_data <= '0;
      o_id_rs2_data <= '0;
      o_id_imm      <= '0;
      o_id_alu_op   <= '0;
      o_id_funct3   <= '0;
      o_id_ctrl     <= '0;
      o_id_illegal  <= 1'b0;
    end else if (!i_stall) begin
      o_id_valid    <= i_if_valid;
      o_id_pc       <= i_if_pc;
      o_id_rs1      <= w_rs1;
      o_id_rs2      <= w_rs2;
      o_id_rd       <= w_rd;
      o_id_rs1_data <= w_rs1_data;
      o_id_rs2_data <= w_rs2_data;
      o_id_imm      <= w_imm;
      o_id_alu_op   <= w_alu_op;
      o_id_funct3   <= w_funct3;
      o_id_ctrl     <= i_if_valid ? w_ctrl : 7'd0;
      o_id_illegal  <= i_if_valid & w_illegal;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-computed expectations checked with immediate assertions.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_stall, i_flush, i_if_valid, i_wb_en;
  logic [31:0] i_if_pc, i_if_instr, i_wb_data;
  logic [4:0]  i_wb_rd;
  logic        o_id_valid, o_id_illegal;
  logic [31:0] o_id_pc, o_id_rs1_data, o_id_rs2_data, o_id_imm;
  logic [4:0]  o_id_rs1, o_id_rs2, o_id_rd;
  logic [3:0]  o_id_alu_op;
  logic [2:0]  o_id_funct3;
  logic [6:0]  o_id_ctrl;

  int errors = 0;
  int checks = 0;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .i_stall(i_stall), .i_flush(i_flush),
    .i_if_valid(i_if_valid), .i_if_pc(i_if_pc), .i_if_instr(i_if_instr),
    .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .o_id_valid(o_id_valid), .o_id_pc(o_id_pc), .o_id_rs1(o_id_rs1), .o_id_rs2(o_id_rs2),
    .o_id_rd(o_id_rd), .o_id_rs1_data(o_id_rs1_data), .o_id_rs2_data(o_id_rs2_data),
    .o_id_imm(o_id_imm), .o_id_alu_op(o_id_alu_op), .o_id_funct3(o_id_funct3),
    .o_id_ctrl(o_id_ctrl), .o_id_illegal(o_id_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_if(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    i_if_valid = v;
    i_if_pc    = pc;
    i_if_instr = instr;
  endtask

  task automatic drive_wb(input logic en, input logic [4:0] rd, input logic [31:0] d);
    i_wb_en   = en;
    i_wb_rd   = rd;
    i_wb_data = d;
  endtask

  initial begin
    rst_n = 1'b0;
    i_stall = 1'b0;
    i_flush = 1'b0;
    drive_if(1'b0, 32'h0, 32'h0);
    drive_wb(1'b0, 5'd0, 32'h0);
    #2;
    chk("reset_valid", {31'd0, o_id_valid}, 32'd0);
    chk("reset_pc", o_id_pc, 32'd0);
    chk("reset_ctrl", {25'd0, o_id_ctrl}, 32'd0);
    #10 rst_n = 1'b1;

    // write x5, then decode ADD x3,x5,x0
    drive_wb(1'b1, 5'd5, 32'h1234);
    step();
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_if(1'b1, 32'h100, 32'h000281B3);
    step();
    chk("add_valid", {31'd0, o_id_valid}, 32'd1);
    chk("add_pc", o_id_pc, 32'h100);
    chk("add_rs1", {27'd0, o_id_rs1}, 32'd5);
    chk("add_rd", {27'd0, o_id_rd}, 32'd3);
    chk("add_rs1_data", o_id_rs1_data, 32'h1234);
    chk("add_rs2_data", o_id_rs2_data, 32'h0);
    chk("add_alu", {28'd0, o_id_alu_op}, 32'd0);
    chk("add_ctrl", {25'd0, o_id_ctrl}, 32'h10);
    chk("add_illegal", {31'd0, o_id_illegal}, 32'd0);

    // bypass: wb x6 in the same cycle as SUB x7,x6,x6
    drive_wb(1'b1, 5'd6, 32'hDEAD);
    drive_if(1'b1, 32'h104, 32'h406303B3);
    step();
    chk("sub_rs1_data", o_id_rs1_data, 32'hDEAD);
    chk("sub_rs2_data", o_id_rs2_data, 32'hDEAD);
    chk("sub_alu", {28'd0, o_id_alu_op}, 32'd1);
    chk("sub_rd", {27'd0, o_id_rd}, 32'd7);

    // x0: write attempt with bypass candidate, then plain read
    drive_wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    drive_if(1'b1, 32'h108, 32'hFFF00093);
    step();
    chk("addi_bypass_x0", o_id_rs1_data, 32'h0);
    drive_wb(1'b0, 5'd0, 32'h0);
    step();
    chk("addi_read_x0", o_id_rs1_data, 32'h0);
    chk("addi_imm", o_id_imm, 32'hFFFF_FFFF);
    chk("addi_ctrl", {25'd0, o_id_ctrl}, 32'h30);
    chk("addi_rd", {27'd0, o_id_rd}, 32'd1);

    // immediates
    drive_if(1'b1, 32'h10C, 32'hFE000EE3);
    step();
    chk("beq_imm", o_id_imm, 32'hFFFF_FFFC);
    chk("beq_ctrl", {25'd0, o_id_ctrl}, 32'h02);
    chk("beq_alu", {28'd0, o_id_alu_op}, 32'd1);
    chk("beq_rd_zero", {27'd0, o_id_rd}, 32'd0);
    drive_if(1'b1, 32'h110, 32'h008000EF);
    step();
    chk("jal_imm", o_id_imm, 32'd8);
    chk("jal_ctrl", {25'd0, o_id_ctrl}, 32'h51);
    chk("jal_rd", {27'd0, o_id_rd}, 32'd1);
    drive_if(1'b1, 32'h114, 32'h12345037);
    step();
    chk("lui_imm", o_id_imm, 32'h12345000);
    chk("lui_alu", {28'd0, o_id_alu_op}, 32'd10);
    chk("lui_rs1_zero", {27'd0, o_id_rs1}, 32'd0);
    chk("lui_ctrl", {25'd0, o_id_ctrl}, 32'h10);

    // SRAI x1,x2,3 legal; SLLI with funct7=0100000 illegal
    drive_if(1'b1, 32'h118, 32'h40315093);
    step();
    chk("srai_alu", {28'd0, o_id_alu_op}, 32'd7);
    chk("srai_illegal", {31'd0, o_id_illegal}, 32'd0);
    drive_if(1'b1, 32'h11C, 32'h40001013);
    step();
    chk("slli_bad_illegal", {31'd0, o_id_illegal}, 32'd1);
    chk("slli_bad_ctrl", {25'd0, o_id_ctrl}, 32'd0);

    // stall: operands frozen, writeback during stall not seen by held instruction
    drive_if(1'b1, 32'h200, 32'h000281B3);
    step();
    i_stall = 1'b1;
    drive_if(1'b1, 32'h300, 32'h12345037);
    drive_wb(1'b1, 5'd5, 32'h5555);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_pc", o_id_pc, 32'h200);
      chk("stall_rs1_data", o_id_rs1_data, 32'h1234);
    end
    i_stall = 1'b0;
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_if(1'b1, 32'h204, 32'h000281B3);
    step();
    chk("post_stall_rs1_data", o_id_rs1_data, 32'h5555);
    chk("post_stall_pc", o_id_pc, 32'h204);

    // SW x5,4(x6)
    drive_if(1'b1, 32'h208, 32'h00532223);
    step();
    chk("sw_imm", o_id_imm, 32'd4);
    chk("sw_ctrl", {25'd0, o_id_ctrl}, 32'h24);
    chk("sw_rs1_data", o_id_rs1_data, 32'hDEAD);
    chk("sw_rs2_data", o_id_rs2_data, 32'h5555);

    // flush beats stall
    i_flush = 1'b1;
    i_stall = 1'b1;
    step();
    chk("flush_valid", {31'd0, o_id_valid}, 32'd0);
    chk("flush_pc", o_id_pc, 32'd0);
    chk("flush_imm", o_id_imm, 32'd0);
    i_flush = 1'b0;
    i_stall = 1'b0;

    // unsupported opcode
    drive_if(1'b1, 32'h20C, 32'h0000007F);
    step();
    chk("ill_valid", {31'd0, o_id_valid}, 32'd1);
    chk("ill_flag", {31'd0, o_id_illegal}, 32'd1);
    chk("ill_ctrl", {25'd0, o_id_ctrl}, 32'd0);

    // bubble load: ctrl/illegal cleared
    drive_if(1'b0, 32'h210, 32'h000281B3);
    step();
    chk("bubble_valid", {31'd0, o_id_valid}, 32'd0);
    chk("bubble_ctrl", {25'd0, o_id_ctrl}, 32'd0);
    chk("bubble_pc", o_id_pc, 32'h210);

    // mid-stream asynchronous reset
    drive_if(1'b1, 32'h214, 32'h000281B3);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, o_id_valid}, 32'd0);
    chk("midrst_pc", o_id_pc, 32'd0);
    chk("midrst_rs1_data", o_id_rs1_data, 32'd0);
    #3 rst_n = 1'b1;
    step();
    chk("after_rst_x5", o_id_rs1_data, 32'd0);
    chk("after_rst_valid", {31'd0, o_id_valid}, 32'd1);
    chk("after_rst_pc", o_id_pc, 32'h214);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
